// File: rtl/pe_array_seq_pkg.sv
// Shared types and helpers for the PE-array sequencer: FSM state encoding and
// the skewed-pipeline latency that sizes the result-valid delay line.
package pe_array_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    DONE
  } seq_state_t;

  // Latency from the grid input edge to the grid output edge, in cycles.
  function automatic int calc_lat(input int rows, input int cols, input int mac_lat);
    return rows + cols + mac_lat - 1;
  endfunction

endpackage

// File: rtl/pe_seq_valid_pipe.sv
// Fixed-depth 1-bit delay line with synchronous clear; carries the activation
// valid bit alongside the data skewing through the PE grid.
module pe_seq_valid_pipe #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_bit,
  output logic o_bit
);

  logic [DEPTH-1:0] r_sr;

  // NOTE: non-blocking assignments let every stage sample its neighbour's old
  // value on the same edge; blocking would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_bit;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_bit = r_sr[DEPTH-1];

endmodule

// File: rtl/pe_array_sequencer.sv
// Job sequencer for a ROWS x COLS int8 systolic grid: weight load, activation
// streaming, pipeline drain. Optional perf counters via PE_ARRAY_SEQ_PERF_EN.
module pe_array_sequencer
  import pe_array_seq_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAC_LAT = 2,
  parameter int LENW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] cfg_len,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  input  logic            w_valid,
  output logic            w_ready,
  output logic [ROWS-1:0] e_enable,
  input  logic            act_valid,
  output logic            act_ready,
  output logic            act_sel,
  output logic            res_valid
`ifdef PE_ARRAY_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_busy_cycles,
  output logic [31:0]     perf_bubble_cycles
`endif
);

  localparam int LAT = calc_lat(ROWS, COLS, MAC_LAT);

  seq_state_t      r_state;
  seq_state_t      w_next;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_w_cnt;
  logic [LENW-1:0] r_beat_cnt;
  logic [LENW-1:0] r_drain_cnt;

  logic w_start_acc;
  logic w_abort;
  logic w_w_acc;
  logic w_a_acc;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_abort     = abort && (r_state != IDLE);
  assign w_w_acc     = (r_state == LOAD) && w_valid;
  assign w_a_acc     = (r_state == COMPUTE) && act_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    w_ready   = (r_state == LOAD);
    act_ready = (r_state == COMPUTE);
    act_sel   = w_a_acc;
    e_enable  = {ROWS{w_w_acc}};

    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (cfg_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (w_w_acc && (r_w_cnt == LENW'(ROWS - 1))) begin
          w_next = COMPUTE;
        end
      end
      COMPUTE: begin
        // Compare against len-1 so a full-scale length never wraps the counter.
        if (w_a_acc && (r_beat_cnt == (r_len - LENW'(1)))) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == LENW'(LAT - 1)) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase

    if (w_abort) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len       <= '0;
      r_w_cnt     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (w_start_acc || w_abort) begin
      if (w_start_acc) begin
        r_len <= cfg_len;
      end
      r_w_cnt     <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_w_acc) begin
        r_w_cnt <= r_w_cnt + LENW'(1);
      end
      if (w_a_acc) begin
        r_beat_cnt <= r_beat_cnt + LENW'(1);
      end
      if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + LENW'(1);
      end
    end
  end

  pe_seq_valid_pipe #(
    .DEPTH (LAT)
  ) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_abort),
    .i_bit (w_a_acc),
    .o_bit (res_valid)
  );

`ifdef PE_ARRAY_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_cycles   <= '0;
      perf_bubble_cycles <= '0;
    end else if (w_start_acc) begin
      perf_busy_cycles   <= '0;
      perf_bubble_cycles <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if ((r_state == COMPUTE) && !act_valid && (perf_bubble_cycles != '1)) begin
        perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pe_array_sequencer.md
# pe_array_sequencer

Control sequencer for a ROWS×COLS systolic grid of int8 processing elements. It runs one tile job at a time. Each job loads stationary weights through the PE column `e` chain, streams activation beats into the grid edge and drains the skewed pipeline. It generates the per-row stationary-operand load enable, the activation handshake and a result-valid strobe aligned with the grid output edge. It sits between the tile DMA/command front end and the PE grid.

## Interface
- `ROWS`, 4, PE rows; also the number of weight beats per load.
- `COLS`, 4, PE columns.
- `MAC_LAT`, 2, cycles from PE operand register to valid MAC output.
- `LENW`, 16, width of the job length field.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled in IDLE only.
- `cfg_len`  in  LENW  activation beats in the job; captured on start.
- `abort`  in  1  cancel the current job.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `w_valid`  in  1  weight beat available.
- `w_ready`  out  1  weight beat accepted; high in LOAD.
- `e_enable`  out  ROWS  stationary-operand load enable, same bit for all rows.
- `act_valid`  in  1  activation beat available.
- `act_ready`  out  1  activation beat accepted; high in COMPUTE.
- `act_sel`  out  1  1 = drive the beat into the grid, 0 = drive zeros (bubble).
- `res_valid`  out  1  grid output edge carries a real result.

## Operation
- States: IDLE → LOAD → COMPUTE → DRAIN → DONE → IDLE.
- IDLE:
  - start=1 with cfg_len≠0: capture the length, clear counters, go to LOAD.
  - start=1 with cfg_len=0: go directly to DONE. No weight or activation beats are taken.
- LOAD:
  - `w_ready`=1.
  - On each cycle with w_valid=1, all bits of `e_enable` are 1 and the weight counter increments.
  - After ROWS accepted beats, go to COMPUTE.
  - Cycles with w_valid=0 leave `e_enable`=0 and hold the count.
- COMPUTE:
  - `act_ready`=1 and `act_sel`=act_valid.
  - PE operand registers are free-running, so a missing beat becomes a zero bubble.
  - The beat counter increments on act_valid. After cfg_len accepted beats, go to DRAIN.
- DRAIN: a counter runs LAT = ROWS+COLS+MAC_LAT−1 cycles, then the block goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Valid pipe:
  - LAT-deep shift register that shifts every cycle.
  - Input bit = act_valid & act_ready. Output bit = `res_valid`.
  - Outside COMPUTE the pipe is fed 0.
- abort:
  - Any state other than IDLE goes to IDLE on the next edge.
  - The valid pipe and counters clear. `done` is not pulsed.
  - abort in IDLE is ignored. abort and start in the same IDLE cycle: start wins.
- start while busy is ignored; no queueing.
- Counters are LENW bits wide. cfg_len = 2^LENW−1 must complete without wrap.

## Timing
- Reset values: state IDLE; busy, done, w_ready, act_ready, act_sel, res_valid = 0; e_enable = 0; valid pipe all 0.
- Start accepted at edge N: busy=1 and w_ready=1 from cycle N+1.
- `e_enable` and `act_sel` are combinational from state and the input valid. They are registered by the PEs on the same edge as the beat.
- The first activation accepted at edge M gives res_valid=1 in cycle M+LAT.
- Back-to-back jobs: minimum one IDLE cycle after DONE.
- Job length, cycles from start to done with no stalls: 1 + ROWS + cfg_len + LAT + 1.

## Configuration
- `PE_ARRAY_SEQ_PERF_EN`:
  - Defined: adds 32-bit saturating counters `perf_busy_cycles` and `perf_bubble_cycles` (COMPUTE cycles with act_valid=0) as extra outputs.
  - Both counters clear on start acceptance and reset to 0.
  - Not defined: the counters and ports are absent and behaviour is otherwise identical.

## Structure
- Package `pe_array_seq_pkg`:
  - the state enum `seq_state_t` (IDLE, LOAD, COMPUTE, DRAIN, DONE);
  - the function computing LAT from ROWS, COLS and MAC_LAT.
- Sub-module `pe_seq_valid_pipe`: parameterised-depth 1-bit shift register with synchronous clear. It is instantiated once for the valid pipe.

## Test plan
- Nominal run, ROWS=4, COLS=4, MAC_LAT=2 (LAT=9), cfg_len=3, no stalls:
  - 4 cycles with e_enable=4'hF;
  - res_valid high for 3 cycles, the first 9 cycles after the first act beat;
  - done 18 cycles after the start edge.
- Weight stalls: w_valid pattern 1,0,1,0,1,1 → exactly 4 e_enable pulses; COMPUTE entered after the 6th cycle.
- Activation bubbles: cfg_len=2 with act_valid 1,0,0,1 → act_sel 1,0,0,1; res_valid pattern 1,0,0,1 delayed by LAT; `perf_bubble_cycles`=2 when the macro is enabled.
- cfg_len=0 → done pulses 2 cycles after start; w_ready, act_ready and res_valid never assert.
- Abort mid-DRAIN, 3 cycles in → IDLE next cycle; res_valid drops immediately; no done pulse; a new start is accepted 1 cycle later.
- Reset asserted asynchronously mid-COMPUTE → all outputs 0 before the next edge; start is ignored while rst=0.
